inst_fetch_queue: RTL



---
 rtl/inst_fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// FWFT instruction-fetch buffer with program-order ID tagging and flush-on-jump.
// Optional same-cycle bypass of an empty queue when IFQ_BYPASS_EN is defined.
module inst_fetch_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int PID_W    = 2,
  parameter int PID_INIT = 2,
  parameter int PID_STEP = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        inst_i,
  input  logic [ADDR_W-1:0]        instAddr_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        inst_o,
  output logic [ADDR_W-1:0]        instAddr_o,
  output logic [PID_W-1:0]         pID_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             full;
  logic             bypass;
  logic             bypass_xfer;
  logic             push;
  logic             pop;

  // Pointers carry one extra MSB so full and empty differ while indices match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PTR_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

`ifdef IFQ_BYPASS_EN
  assign bypass = (count == '0) && valid_i && !flush_i;
  always_comb begin
    valid_o    = (count != '0) || bypass;
    inst_o     = head[DATA_W-1:0];
    instAddr_o = head[ENT_W-1:DATA_W];
    if (bypass) begin
      inst_o     = inst_i;
      instAddr_o = instAddr_i;
    end
  end
`else
  assign bypass     = 1'b0;
  assign valid_o    = (count != '0);
  assign inst_o     = head[DATA_W-1:0];
  assign instAddr_o = head[ENT_W-1:DATA_W];
`endif

  assign bypass_xfer = bypass && ready_i;
  assign pop         = valid_o && ready_i && !flush_i;
  // A completed bypass consumes the response without touching storage.
  assign push        = valid_i && !flush_i && (!full || pop) && !bypass_xfer;

  // One slot of headroom is kept for a fetch response already in flight.
  assign ready_o    = (count <= PTR_W'(DEPTH - 2));
  assign count_o    = count;
  assign pID_o      = pid_q;
  assign overflow_o = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pid_d      = pid_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[IDX_W-1:0]] = {instAddr_i, inst_i};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop && !bypass_xfer) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        pid_d = pid_q + PID_W'(PID_STEP);
      end
      if (valid_i && full && !pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pid_q      <= PID_W'(PID_INIT);
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pid_q      <= pid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
